// File: rtl/pipe_stage_fifo.sv
// ============================================================================
// Module   : pipe_stage_fifo
// Purpose  : valid/ready pipeline stage holding up to DEPTH entries in a ring
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_fifo #(
  parameter int               WIDTH      = 96,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0] C_LAST  = PW'(DEPTH-1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  // Non-power-of-two depths need an explicit wrap rather than relying on overflow.
  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  assign o_ready = (r_count < C_DEPTH);
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : BUBBLE_VAL;

  assign w_push = i_valid & o_ready & ~i_flush;
  assign w_pop  = o_valid & i_ready & ~i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is left unreset; o_data masks it with BUBBLE_VAL when empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_fifo.sv
// ============================================================================
// Module   : tb_pipe_stage_fifo
// Purpose  : directed checks of pipe_stage_fifo at DEPTH=2 and DEPTH=1
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_fifo;

  logic        clk;
  logic        rst;

  logic        valid_a, ready_a, flush_a;
  logic [95:0] data_a;
  logic        o_ready_a, o_valid_a;
  logic [95:0] o_data_a;
  logic [1:0]  o_count_a;

  logic        valid_b, ready_b, flush_b;
  logic [7:0]  data_b;
  logic        o_ready_b, o_valid_b;
  logic [7:0]  o_data_b;
  logic [0:0]  o_count_b;

  int n_cmp;
  int n_err;

  pipe_stage_fifo #(.WIDTH(96), .DEPTH(2), .BUBBLE_VAL('0)) u_dut_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(valid_a),
    .o_ready(o_ready_a),
    .i_data (data_a),
    .o_valid(o_valid_a),
    .i_ready(ready_a),
    .o_data (o_data_a),
    .i_flush(flush_a),
    .o_count(o_count_a)
  );

  pipe_stage_fifo #(.WIDTH(8), .DEPTH(1), .BUBBLE_VAL(8'h00)) u_dut_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(valid_b),
    .o_ready(o_ready_b),
    .i_data (data_b),
    .o_valid(o_valid_b),
    .i_ready(ready_b),
    .o_data (o_data_b),
    .i_flush(flush_b),
    .o_count(o_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [95:0] p0;
    logic [95:0] pa, pb, pc, pd1, pd2, pd3, pe;
    n_cmp = 0;
    n_err = 0;

    rst = 1'b1;
    valid_a = 1'b0; ready_a = 1'b0; flush_a = 1'b0; data_a = '0;
    valid_b = 1'b0; ready_b = 1'b0; flush_b = 1'b0; data_b = '0;
    tick();
    tick();
    chk("rst_valid", 128'(o_valid_a), 128'(1'b0));
    chk("rst_count", 128'(o_count_a), 128'(2'd0));
    chk("rst_ready", 128'(o_ready_a), 128'(1'b1));
    chk("rst_data",  128'(o_data_a),  128'(0));
    chk("rst_ready_d1", 128'(o_ready_b), 128'(1'b1));
    rst = 1'b0;
    tick();

    // Single pass
    p0 = {32'h0000_0100, 32'h0050_0093, 32'h0000_0104};
    valid_a = 1'b1; ready_a = 1'b1; data_a = p0;
    tick();
    chk("sp_valid", 128'(o_valid_a), 128'(1'b1));
    chk("sp_data",  128'(o_data_a),  128'(p0));
    chk("sp_count", 128'(o_count_a), 128'(2'd1));
    valid_a = 1'b0;
    tick();
    chk("sp_valid_after", 128'(o_valid_a), 128'(1'b0));
    chk("sp_data_after",  128'(o_data_a),  128'(0));

    // Stall fill then drain
    pa = 96'hA; pb = 96'hB; pc = 96'hC;
    ready_a = 1'b0; valid_a = 1'b1; data_a = pa;
    tick();
    data_a = pb;
    tick();
    chk("fill_count", 128'(o_count_a), 128'(2'd2));
    chk("fill_ready", 128'(o_ready_a), 128'(1'b0));
    chk("fill_head",  128'(o_data_a),  128'(pa));
    data_a = pc;
    tick();
    chk("stall_hold_count", 128'(o_count_a), 128'(2'd2));
    chk("stall_hold_head",  128'(o_data_a),  128'(pa));
    ready_a = 1'b1;
    tick();
    chk("drain1_data",  128'(o_data_a),  128'(pb));
    chk("drain1_ready", 128'(o_ready_a), 128'(1'b1));
    chk("drain1_count", 128'(o_count_a), 128'(2'd1));
    tick();
    chk("drain2_data",  128'(o_data_a),  128'(pc));
    chk("drain2_count", 128'(o_count_a), 128'(2'd1));
    valid_a = 1'b0;
    tick();
    chk("drain3_valid", 128'(o_valid_a), 128'(1'b0));

    // Streaming 0x1..0x8 with no bubbles
    valid_a = 1'b1; ready_a = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_a = 96'(i);
      tick();
      chk("stream_data",  128'(o_data_a),  128'(i));
      chk("stream_valid", 128'(o_valid_a), 128'(1'b1));
      chk("stream_count", 128'(o_count_a), 128'(2'd1));
    end
    valid_a = 1'b0;
    tick();
    chk("stream_end_valid", 128'(o_valid_a), 128'(1'b0));

    // Flush while full drops the incoming payload too
    pd1 = 96'hD1; pd2 = 96'hD2; pd3 = 96'hD3;
    ready_a = 1'b0; valid_a = 1'b1; data_a = pd1;
    tick();
    data_a = pd2;
    tick();
    chk("pre_flush_count", 128'(o_count_a), 128'(2'd2));
    data_a = pd3; flush_a = 1'b1;
    tick();
    chk("flush_count", 128'(o_count_a), 128'(2'd0));
    chk("flush_valid", 128'(o_valid_a), 128'(1'b0));
    chk("flush_data",  128'(o_data_a),  128'(0));
    chk("flush_ready", 128'(o_ready_a), 128'(1'b1));
    flush_a = 1'b0; valid_a = 1'b0; ready_a = 1'b1;
    tick();
    chk("post_flush_valid", 128'(o_valid_a), 128'(1'b0));

    // Held flush with pushes offered keeps the stage empty
    valid_a = 1'b1; flush_a = 1'b1; data_a = 96'hF0;
    tick();
    tick();
    chk("multi_flush_count", 128'(o_count_a), 128'(2'd0));
    pe = 96'hE;
    flush_a = 1'b0; data_a = pe; ready_a = 1'b0;
    tick();
    chk("resume_data",  128'(o_data_a),  128'(pe));
    chk("resume_count", 128'(o_count_a), 128'(2'd1));

    // Asynchronous reset between edges with count=1
    valid_a = 1'b0;
    tick();
    chk("pre_rst_count", 128'(o_count_a), 128'(2'd1));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(o_valid_a), 128'(1'b0));
    chk("arst_count", 128'(o_count_a), 128'(2'd0));
    chk("arst_data",  128'(o_data_a),  128'(0));
    chk("arst_ready", 128'(o_ready_a), 128'(1'b1));
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 128'(o_valid_a), 128'(1'b0));

    // DEPTH=1: one transfer every other cycle, o_ready toggles
    valid_b = 1'b1; ready_b = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      data_b = 8'(8'h10 + (j - 1) / 2);
      tick();
      chk("d1_ready", 128'(o_ready_b), 128'((j % 2) == 0));
      chk("d1_valid", 128'(o_valid_b), 128'((j % 2) == 1));
      chk("d1_data",  128'(o_data_b),
          ((j % 2) == 1) ? 128'(8'h10 + (j - 1) / 2) : 128'(0));
    end
    valid_b = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
